// File: rtl/aes_spi_ctrl.sv
// AES SPI front-end controller.
// Collects key and data frames from a shared serial input, hands them to the
// key-expansion and cipher engines, and streams the cipher result back on miso.
module aes_spi_ctrl #(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs_data,
  input  logic               cs_key,
  input  logic               mosi,
  output logic               miso,
  output logic [NK*32-1:0]   key_out,
  output logic               key_valid,
  input  logic               kexp_done,
  output logic [127:0]       blk_out,
  output logic               mode_out,
  output logic               start,
  input  logic               core_done,
  input  logic [127:0]       core_result,
  output logic [127:0]       result,
  output logic               result_valid,
  output logic               busy,
  output logic               err
);

  localparam int KLEN = NK * 32;
  localparam int DLEN = 129;
  localparam int KCW  = $clog2(KLEN + 2);
  localparam int DCW  = $clog2(DLEN + 2);

  // Reject key sizes the expansion engine cannot handle at elaboration time.
  if (!(NK == 4 || NK == 6 || NK == 8) || NR < 1) begin : g_param_check
    $error("aes_spi_ctrl: NK must be 4, 6 or 8 and NR positive");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, READY, RUN} state_e;

  state_e             state_q, state_d;
  logic [KLEN-1:0]    ksr_q, ksr_d;          // key input shift register
  logic [KCW-1:0]     kcnt_q, kcnt_d;        // key bits seen, saturating
  logic               kact_q, kact_d;        // key frame in progress
  logic               kdrop_q, kdrop_d;      // current key frame is discarded
  logic [DLEN-1:0]    dsr_q, dsr_d;          // {mode, block} input shift register
  logic [DCW-1:0]     dcnt_q, dcnt_d;
  logic               dact_q, dact_d;
  logic               ddrop_q, ddrop_d;
  logic [127:0]       osr_q, osr_d;          // result output shift register
  logic [KLEN-1:0]    key_out_q, key_out_d;
  logic               key_valid_q, key_valid_d;
  logic [127:0]       blk_q, blk_d;
  logic               mode_q, mode_d;
  logic               start_q, start_d;
  logic [127:0]       result_q, result_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;

  logic busy_w;
  assign busy_w = (state_q == EXPAND) || (state_q == RUN);

  // Next-state logic for the FSM, both frame channels and all output registers.
  always_comb begin
    logic k_drop_now;
    logic d_drop_now;
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    ksr_d       = ksr_q;
    kcnt_d      = kcnt_q;
    kact_d      = kact_q;
    kdrop_d     = kdrop_q;
    dsr_d       = dsr_q;
    dcnt_d      = dcnt_q;
    dact_d      = dact_q;
    ddrop_d     = ddrop_q;
    osr_d       = osr_q;
    key_out_d   = key_out_q;
    key_valid_d = 1'b0;
    blk_d       = blk_q;
    mode_d      = mode_q;
    start_d     = 1'b0;
    result_d    = result_q;
    rvalid_d    = rvalid_q;
    err_d       = err_q;
    k_drop_now  = 1'b0;
    d_drop_now  = 1'b0;

    // Overlapping selects corrupt both frames on the shared mosi line.
    if (!cs_key && !cs_data) err_d = 1'b1;

    // Key channel: a frame opened while busy, or hit by an overlap, is dropped.
    if (!cs_key) begin
      k_drop_now = (kact_q ? kdrop_q : busy_w) || !cs_data;
      if (!kact_q && busy_w) err_d = 1'b1;
      kact_d  = 1'b1;
      kdrop_d = k_drop_now;
      if (!kact_q)                        kcnt_d = KCW'(1);
      else if (kcnt_q != KCW'(KLEN + 1))  kcnt_d = kcnt_q + KCW'(1);
      if (!k_drop_now) ksr_d = {ksr_q[KLEN-2:0], mosi};
    end else if (kact_q) begin
      kact_d  = 1'b0;
      kdrop_d = 1'b0;
      if (!kdrop_q) begin
        if (kcnt_q == KCW'(KLEN) && (state_q == IDLE || state_q == READY)) begin
          key_out_d   = ksr_q;
          key_valid_d = 1'b1;
          state_d     = EXPAND;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Data channel: shifts the block in and the previous result out together.
    if (!cs_data) begin
      d_drop_now = (dact_q ? ddrop_q : busy_w) || !cs_key;
      if (!dact_q && busy_w) err_d = 1'b1;
      dact_d  = 1'b1;
      ddrop_d = d_drop_now;
      if (!dact_q)                        dcnt_d = DCW'(1);
      else if (dcnt_q != DCW'(DLEN + 1))  dcnt_d = dcnt_q + DCW'(1);
      if (!d_drop_now) dsr_d = {dsr_q[DLEN-2:0], mosi};
      osr_d = {osr_q[126:0], 1'b0};
    end else if (dact_q) begin
      dact_d  = 1'b0;
      ddrop_d = 1'b0;
      // A full readout consumes the result even if the frame is rejected.
      if (dcnt_q >= DCW'(128)) rvalid_d = 1'b0;
      if (!ddrop_q) begin
        if (dcnt_q == DCW'(DLEN) && state_q == READY) begin
          blk_d   = dsr_q[127:0];
          mode_d  = dsr_q[128];
          start_d = 1'b1;
          state_d = RUN;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Engine handshakes; completion pulses in other states are ignored.
    case (state_q)
      EXPAND: if (kexp_done) state_d = READY;
      RUN: begin
        if (core_done) begin
          state_d  = READY;
          result_d = core_result;
          rvalid_d = 1'b1;
          osr_d    = core_result;
        end
      end
      default: ;
    endcase
  end

  // State registers; after reset both channels sit in a discarded frame until
  // their select is seen high, so a frame straddling reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ksr_q       <= '0;
      kcnt_q      <= '0;
      kact_q      <= 1'b1;
      kdrop_q     <= 1'b1;
      dsr_q       <= '0;
      dcnt_q      <= '0;
      dact_q      <= 1'b1;
      ddrop_q     <= 1'b1;
      osr_q       <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      blk_q       <= '0;
      mode_q      <= 1'b0;
      start_q     <= 1'b0;
      result_q    <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      ksr_q       <= ksr_d;
      kcnt_q      <= kcnt_d;
      kact_q      <= kact_d;
      kdrop_q     <= kdrop_d;
      dsr_q       <= dsr_d;
      dcnt_q      <= dcnt_d;
      dact_q      <= dact_d;
      ddrop_q     <= ddrop_d;
      osr_q       <= osr_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      blk_q       <= blk_d;
      mode_q      <= mode_d;
      start_q     <= start_d;
      result_q    <= result_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  assign miso         = !cs_data && osr_q[127];
  assign key_out      = key_out_q;
  assign key_valid    = key_valid_q;
  assign blk_out      = blk_q;
  assign mode_out     = mode_q;
  assign start        = start_q;
  assign result       = result_q;
  assign result_valid = rvalid_q;
  assign busy         = busy_w;
  assign err          = err_q;

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// Self-checking bench for aes_spi_ctrl: directed scenarios plus a randomized
// sequence, checked by a scoreboard against a behavioural model.
`timescale 1ns/1ps
module tb_aes_spi_ctrl;

  localparam int KLEN = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, cs_data = 1'b1, cs_key = 1'b1, mosi = 1'b0;
  logic         kexp_done = 1'b0, core_done = 1'b0;
  logic [127:0] core_result = '0;
  logic         miso, key_valid, mode_out, start, result_valid, busy, err;
  logic [127:0] key_out, blk_out, result;

  aes_spi_ctrl #(.NK(4)) u_dut (
    .clk(clk), .rst(rst), .cs_data(cs_data), .cs_key(cs_key), .mosi(mosi),
    .miso(miso), .key_out(key_out), .key_valid(key_valid), .kexp_done(kexp_done),
    .blk_out(blk_out), .mode_out(mode_out), .start(start), .core_done(core_done),
    .core_result(core_result), .result(result), .result_valid(result_valid),
    .busy(busy), .err(err)
  );

  // Second instance with a 256-bit key for the key-length boundary.
  logic         rst8 = 1'b1, cs_key8 = 1'b1, mosi8 = 1'b0;
  logic         miso8, key_valid8, mode_out8, start8, result_valid8, busy8, err8;
  logic [255:0] key_out8;
  logic [127:0] blk_out8, result8;

  aes_spi_ctrl #(.NK(8)) u_dut8 (
    .clk(clk), .rst(rst8), .cs_data(1'b1), .cs_key(cs_key8), .mosi(mosi8),
    .miso(miso8), .key_out(key_out8), .key_valid(key_valid8), .kexp_done(1'b0),
    .blk_out(blk_out8), .mode_out(mode_out8), .start(start8), .core_done(1'b0),
    .core_result(128'h0), .result(result8), .result_valid(result_valid8),
    .busy(busy8), .err(err8)
  );

  int checks = 0;
  int errors = 0;
  int kv8_cnt = 0;
  always @(posedge clk) if (key_valid8) kv8_cnt <= kv8_cnt + 1;

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic [127:0] exp_key_q[$];
  logic [128:0] exp_start_q[$];
  logic [127:0] exp_res_q[$];

  // Behavioural model of the controller's externally visible state.
  logic [127:0] m_key, m_blk, m_res;
  logic         m_mode, m_err, m_rv, m_expanding, m_running, m_have_key;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_blk = '0; m_res = '0; m_mode = 1'b0; m_err = 1'b0; m_rv = 1'b0;
    m_expanding = 1'b0; m_running = 1'b0; m_have_key = 1'b0;
    exp_key_q.delete(); exp_start_q.delete(); exp_res_q.delete();
  endtask

  // Monitor: compares every key_valid, start and new result against the queues.
  logic kv_prev = 1'b0, st_prev = 1'b0, rv_prev = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (key_valid) begin
      check("key_valid_single_cycle", {255'b0, kv_prev}, 256'd0);
      check("key_valid_expected", {255'b0, exp_key_q.size() > 0}, 256'd1);
      if (exp_key_q.size() > 0) check("key_out", key_out, exp_key_q.pop_front());
    end
    if (start) begin
      check("start_single_cycle", {255'b0, st_prev}, 256'd0);
      check("start_expected", {255'b0, exp_start_q.size() > 0}, 256'd1);
      if (exp_start_q.size() > 0) check("mode_blk_out", {mode_out, blk_out}, exp_start_q.pop_front());
    end
    if (result_valid && !rv_prev) begin
      check("result_expected", {255'b0, exp_res_q.size() > 0}, 256'd1);
      if (exp_res_q.size() > 0) check("result", result, exp_res_q.pop_front());
    end
    kv_prev = key_valid; st_prev = start; rv_prev = result_valid;
  end

  task automatic check_state(input string tag);
    check({tag, ".err"}, err, m_err);
    check({tag, ".busy"}, busy, m_expanding || m_running);
    check({tag, ".result_valid"}, result_valid, m_rv);
    check({tag, ".result"}, result, m_res);
    check({tag, ".key_out"}, key_out, m_key);
    check({tag, ".blk_out"}, blk_out, m_blk);
    check({tag, ".mode_out"}, mode_out, m_mode);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".key_out"}, key_out, 0);
    check({tag, ".blk_out"}, blk_out, 0);
    check({tag, ".result"}, result, 0);
    check({tag, ".flags"}, {mode_out, key_valid, start, result_valid, busy, err, miso}, 0);
  endtask

  task automatic send_frame(input bit to_key, input logic [255:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (to_key) cs_key = 1'b0; else cs_data = 1'b0;
      mosi = bits[n-1-i];
    end
    @(negedge clk);
    cs_key = 1'b1; cs_data = 1'b1; mosi = 1'b0;
    @(negedge clk);
  endtask

  task automatic op_key(input logic [127:0] k, input int n);
    if (!(m_expanding || m_running) && n == KLEN) begin
      exp_key_q.push_back(k);
      m_key = k; m_expanding = 1'b1; m_have_key = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    send_frame(1'b1, {128'b0, k}, n);
  endtask

  task automatic op_data(input logic mode, input logic [127:0] blk, input int n);
    if (n >= 128) m_rv = 1'b0;
    if (!(m_expanding || m_running) && n == 129 && m_have_key) begin
      exp_start_q.push_back({mode, blk});
      m_blk = blk; m_mode = mode; m_running = 1'b1;
    end else begin
      m_err = 1'b1;
    end
    send_frame(1'b0, {127'b0, mode, blk}, n);
  endtask

  task automatic op_kexp();
    if (m_expanding) begin m_expanding = 1'b0; m_have_key = 1'b1; end
    @(negedge clk); kexp_done = 1'b1;
    @(negedge clk); kexp_done = 1'b0;
  endtask

  task automatic op_core(input logic [127:0] res);
    if (m_running) begin
      exp_res_q.push_back(res);
      m_res = res; m_rv = 1'b1; m_running = 1'b0;
    end
    @(negedge clk); core_result = res; core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
  endtask

  // 128-cycle readout: a complete result stream, but not a legal data frame.
  task automatic op_read(input string tag);
    logic [127:0] got;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk); cs_data = 1'b0; mosi = 1'b0;
      #1 got[127-i] = miso;
    end
    @(negedge clk); cs_data = 1'b1;
    @(negedge clk);
    check({tag, ".miso_stream"}, got, m_res);
    m_rv = 1'b0; m_err = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cs_key = 1'b1; cs_data = 1'b1; kexp_done = 1'b0; core_done = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_k[6];
    int bad_d[6];
    bad_k = '{KLEN - 1, KLEN + 1, KLEN + 2, KLEN + 5, 1, 64};
    bad_d = '{128, 130, 131, 1, 100, 140};
    model_reset();

    // Reset state.
    #1 check_reset_outputs("reset");
    do_reset();
    check_state("post_reset");

    // Known-answer key load and expansion.
    op_key(128'h000102030405060708090a0b0c0d0e0f, KLEN);
    check_state("key_loaded");
    op_kexp();
    check_state("key_expanded");

    // Known-answer encrypt, completion and readout.
    op_data(1'b0, 128'h00112233445566778899aabbccddeeff, 129);
    check_state("data_loaded");
    op_core(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check_state("core_done");
    op_read("kat");
    check_state("after_read");

    // Key frame during RUN is ignored; operation still completes.
    op_data(1'b1, rnd128(), 129);
    op_key(rnd128(), KLEN);
    check_state("key_in_run");
    op_core(rnd128());
    check_state("run_complete");

    // New key in READY re-enters expansion but keeps the result.
    op_key(rnd128(), KLEN);
    check_state("rekey_in_ready");
    op_kexp();

    // Data frame with no expanded key.
    do_reset();
    op_data(1'b0, rnd128(), 129);
    op_core(rnd128());
    check_state("data_in_idle");

    // Overlapping selects abort both frames.
    do_reset();
    op_key(rnd128(), KLEN);
    op_kexp();
    for (int i = 0; i < 129; i++) begin
      @(negedge clk);
      cs_data = 1'b0; mosi = 1'($urandom());
      cs_key = (i == 60) ? 1'b0 : 1'b1;
    end
    @(negedge clk); cs_data = 1'b1; cs_key = 1'b1;
    @(negedge clk);
    m_err = 1'b1; m_rv = 1'b0;
    check_state("both_low");
    op_data(1'b0, rnd128(), 129);
    op_core(rnd128());
    check_state("after_both_low");

    // Reset during RUN, then a stale completion pulse.
    op_data(1'b1, rnd128(), 129);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 check_reset_outputs("rst_in_run");
    @(negedge clk); rst = 1'b0;
    model_reset();
    op_core(rnd128());
    check_state("late_core_done");

    // Randomized sequence.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          op_key(rnd128(), KLEN);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          op_kexp();
        end
        1: begin
          op_data(1'($urandom()), rnd128(), 129);
          if ($urandom_range(0, 1) == 1) op_kexp();
          repeat ($urandom_range(0, 3)) @(negedge clk);
          op_core(rnd128());
          if (m_rv && $urandom_range(0, 1) == 1) op_read("rnd");
        end
        2: op_key(rnd128(), bad_k[$urandom_range(0, 5)]);
        3: op_data(1'($urandom()), rnd128(), bad_d[$urandom_range(0, 5)]);
        4: begin
          op_key(rnd128(), KLEN);
          op_kexp();
          op_data(1'($urandom()), rnd128(), 129);
          op_core(rnd128());
        end
        default: do_reset();
      endcase
      check_state("rnd");
    end

    // 256-bit key instance: short frame rejected, exact frame accepted.
    begin
      logic [255:0] k8;
      k8 = {rnd128(), rnd128()};
      @(negedge clk); rst8 = 1'b0;
      for (int i = 0; i < 255; i++) begin
        @(negedge clk); cs_key8 = 1'b0; mosi8 = k8[254-i];
      end
      @(negedge clk); cs_key8 = 1'b1;
      @(negedge clk); @(negedge clk);
      check("nk8_short.err", err8, 1);
      check("nk8_short.key_out", key_out8, 0);
      check("nk8_short.busy", busy8, 0);
      check("nk8_short.key_valid_count", kv8_cnt, 0);
      for (int i = 0; i < 256; i++) begin
        @(negedge clk); cs_key8 = 1'b0; mosi8 = k8[255-i];
      end
      @(negedge clk); cs_key8 = 1'b1;
      @(negedge clk); @(negedge clk);
      check("nk8_full.key_out", key_out8, k8);
      check("nk8_full.key_valid_count", kv8_cnt, 1);
      check("nk8_full.busy", busy8, 1);
    end

    // Every expected pulse must have been observed.
    repeat (3) @(negedge clk);
    check("pending_key_pulses", exp_key_q.size(), 0);
    check("pending_start_pulses", exp_start_q.size(), 0);
    check("pending_results", exp_res_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
